// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one req/gnt/rvalid bus transaction per op, with load alignment and extension.
// Build option: `MISALIGN_TRAP_EN traps misaligned H/W ops instead of issuing them to the bus.
`timescale 1ns/1ps
module load_store_unit #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  input  logic            op_is_store,
  input  logic [2:0]      op_funct3,
  input  logic [XLEN-1:0] op_addr,
  input  logic [XLEN-1:0] op_wdata,
  output logic            lsu_busy,
  output logic            load_valid,
  output logic [XLEN-1:0] load_data,
  output logic            store_done,
  output logic            bus_err,
  output logic            misaligned_err,
  output logic            dbus_req,
  output logic            dbus_we,
  output logic [XLEN-1:0] dbus_addr,
  output logic [3:0]      dbus_be,
  output logic [XLEN-1:0] dbus_wdata,
  input  logic            dbus_gnt,
  input  logic            dbus_rvalid,
  input  logic [XLEN-1:0] dbus_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  // Counter only needs to reach TIMEOUT_CYCLES-1; it parks there rather than wrapping.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            l_store, l_b, l_h, l_sext;
  logic [1:0]      l_lane;
  logic            is_b, is_h, mis, timeout, done_ok, done_to;
  logic [3:0]      be_n;
  logic [XLEN-1:0] wdata_n, ext;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;

  // Unsigned variants only exist for loads; on a store they fall through to word.
  always_comb begin
    is_b    = (op_funct3 == 3'b000) | (!op_is_store & (op_funct3 == 3'b100));
    is_h    = (op_funct3 == 3'b001) | (!op_is_store & (op_funct3 == 3'b101));
    be_n    = 4'b1111;
    wdata_n = op_wdata;
    if (is_b) begin
      be_n    = 4'b0001 << op_addr[1:0];
      wdata_n = {4{op_wdata[7:0]}};
    end else if (is_h) begin
      be_n    = op_addr[1] ? 4'b1100 : 4'b0011;
      wdata_n = {2{op_wdata[15:0]}};
    end
`ifdef MISALIGN_TRAP_EN
    mis = (is_h & op_addr[0]) | (!is_b & !is_h & (op_addr[1:0] != 2'b00));
`else
    mis = 1'b0;
`endif
  end

  always_comb begin
    byte_v = dbus_rdata[{l_lane, 3'b000} +: 8];
    half_v = dbus_rdata[{l_lane[1], 4'b0000} +: 16];
    if (l_b)      ext = {{(XLEN-8){l_sext & byte_v[7]}}, byte_v};
    else if (l_h) ext = {{(XLEN-16){l_sext & half_v[15]}}, half_v};
    else          ext = dbus_rdata;
  end

  // A response (or grant) in the timeout cycle takes priority over the error.
  assign timeout  = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);
  assign done_ok  = (state == WAIT) & dbus_rvalid;
  assign done_to  = timeout & !done_ok & !((state == REQ) & dbus_gnt);
  assign dbus_req = (state == REQ);
  assign lsu_busy = (state == REQ) | (state == WAIT) | ((state == IDLE) & op_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      l_store        <= 1'b0;
      l_b            <= 1'b0;
      l_h            <= 1'b0;
      l_sext         <= 1'b0;
      l_lane         <= 2'b00;
      load_valid     <= 1'b0;
      load_data      <= '0;
      store_done     <= 1'b0;
      bus_err        <= 1'b0;
      misaligned_err <= 1'b0;
      dbus_we        <= 1'b0;
      dbus_addr      <= '0;
      dbus_be        <= 4'b0000;
      dbus_wdata     <= '0;
    end else begin
      load_valid     <= 1'b0;
      store_done     <= 1'b0;
      bus_err        <= 1'b0;
      misaligned_err <= 1'b0;
      case (state)
        IDLE: if (op_valid) begin
          cnt     <= '0;
          l_store <= op_is_store;
          l_b     <= is_b;
          l_h     <= is_h;
          l_sext  <= !op_funct3[2];
          l_lane  <= op_addr[1:0];
          if (mis) begin
            state          <= DONE;
            misaligned_err <= 1'b1;
            if (op_is_store) store_done <= 1'b1;
            else begin
              load_valid <= 1'b1;
              load_data  <= '0;
            end
          end else begin
            state      <= REQ;
            dbus_we    <= op_is_store;
            dbus_addr  <= {op_addr[XLEN-1:2], 2'b00};
            dbus_be    <= be_n;
            dbus_wdata <= wdata_n;
          end
        end
        REQ, WAIT: begin
          if (cnt != TO_LAST) cnt <= cnt + 1'b1;
          if (done_ok | done_to) begin
            state   <= DONE;
            bus_err <= done_to;
            if (l_store) store_done <= 1'b1;
            else begin
              load_valid <= 1'b1;
              load_data  <= done_ok ? ext : '0;
            end
          end else if ((state == REQ) && dbus_gnt) begin
            state <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit: a default-timeout instance for bus/extension/reset vectors
// and a TIMEOUT_CYCLES=4 instance for the timeout boundary.
`timescale 1ns/1ps
module tb_load_store_unit;
  logic        clk, rst;
  logic        op_valid, op_is_store, gnt, rvalid;
  logic [2:0]  op_funct3;
  logic [31:0] op_addr, op_wdata, rdata;
  logic        lsu_busy, load_valid, store_done, bus_err, misaligned_err, dbus_req, dbus_we;
  logic [31:0] load_data, dbus_addr, dbus_wdata;
  logic [3:0]  dbus_be;

  logic        t_op_valid, t_gnt, t_rvalid;
  logic [31:0] t_rdata;
  logic        t_lsu_busy, t_load_valid, t_store_done, t_bus_err, t_misaligned_err, t_dbus_req, t_dbus_we;
  logic [31:0] t_load_data, t_dbus_addr, t_dbus_wdata;
  logic [3:0]  t_dbus_be;

  int nvec = 0, nerr = 0;
  int lat, reqc, n;
  logic        busy_bad, we_s;
  logic [3:0]  be_s;
  logic [31:0] wd_s, ad_s;

  load_store_unit u_dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_is_store(op_is_store), .op_funct3(op_funct3),
    .op_addr(op_addr), .op_wdata(op_wdata), .lsu_busy(lsu_busy), .load_valid(load_valid),
    .load_data(load_data), .store_done(store_done), .bus_err(bus_err), .misaligned_err(misaligned_err),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
    .dbus_wdata(dbus_wdata), .dbus_gnt(gnt), .dbus_rvalid(rvalid), .dbus_rdata(rdata)
  );

  load_store_unit #(.TIMEOUT_CYCLES(4)) u_to (
    .clk(clk), .rst(rst), .op_valid(t_op_valid), .op_is_store(1'b0), .op_funct3(3'b010),
    .op_addr(32'h0000_0010), .op_wdata(32'h0), .lsu_busy(t_lsu_busy), .load_valid(t_load_valid),
    .load_data(t_load_data), .store_done(t_store_done), .bus_err(t_bus_err),
    .misaligned_err(t_misaligned_err), .dbus_req(t_dbus_req), .dbus_we(t_dbus_we),
    .dbus_addr(t_dbus_addr), .dbus_be(t_dbus_be), .dbus_wdata(t_dbus_wdata), .dbus_gnt(t_gnt),
    .dbus_rvalid(t_rvalid), .dbus_rdata(t_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issues one op, grants on REQ cycle gdly+1, returns rvalid on WAIT cycle rdly; returns at the DONE negedge.
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input int gdly, input int rdly, input logic [31:0] rd);
    @(negedge clk);
    op_valid = 1'b1; op_is_store = st; op_funct3 = f3; op_addr = a; op_wdata = wd;
    @(negedge clk);
    op_valid = 1'b0;
    lat = 1; reqc = 0; busy_bad = 1'b0;
    while (dbus_req && reqc < 50) begin
      reqc++;
      if (reqc == 1) begin be_s = dbus_be; wd_s = dbus_wdata; ad_s = dbus_addr; we_s = dbus_we; end
      if (!lsu_busy) busy_bad = 1'b1;
      if (reqc == gdly + 1) gnt = 1'b1;
      @(negedge clk);
      gnt = 1'b0; lat++;
    end
    if (reqc > 0) begin
      for (int i = 1; i <= rdly; i++) begin
        if (!lsu_busy) busy_bad = 1'b1;
        if (i == rdly) begin rvalid = 1'b1; rdata = rd; end
        @(negedge clk);
        rvalid = 1'b0; lat++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; op_valid = 0; op_is_store = 0; op_funct3 = 0; op_addr = 0; op_wdata = 0;
    gnt = 0; rvalid = 0; rdata = 0; t_op_valid = 0; t_gnt = 0; t_rvalid = 0; t_rdata = 0;
    @(negedge clk);
    chk("rst_busy", {31'b0, lsu_busy}, 0);
    chk("rst_req", {31'b0, dbus_req}, 0);
    chk("rst_ld", load_data, 0);
    chk("rst_bus", {dbus_addr[27:0], dbus_be} | dbus_wdata | {31'b0, dbus_we}, 0);
    chk("rst_pulses", {28'b0, load_valid, store_done, bus_err, misaligned_err}, 0);
    @(negedge clk);
    rst = 1'b0;

    // LB sign-extended from top lane, minimum latency
    run_op(0, 3'b000, 32'h0000_1003, 0, 0, 1, 32'h80AA_BBCC);
    chk("lb_lat", lat, 3);
    chk("lb_valid", {31'b0, load_valid}, 1);
    chk("lb_data", load_data, 32'hFFFF_FF80);
    chk("lb_busy_done", {31'b0, lsu_busy}, 0);
    @(negedge clk);
    chk("lb_pulse1", {31'b0, load_valid}, 0);

    // SH upper half
    run_op(1, 3'b001, 32'h0000_2002, 32'h1234_5678, 0, 1, 0);
    chk("sh_be", be_s, 4'b1100);
    chk("sh_wd", wd_s, 32'h5678_5678);
    chk("sh_addr", ad_s, 32'h0000_2000);
    chk("sh_we", {31'b0, we_s}, 1);
    chk("sh_done", {30'b0, store_done, load_valid}, 2'b10);
    chk("sh_ld_hold", load_data, 32'hFFFF_FF80);
    @(negedge clk);
    chk("sh_pulse1", {31'b0, store_done}, 0);

    // LHU with slow grant and slow response
    run_op(0, 3'b101, 32'h0, 0, 5, 2, 32'h1234_F00D);
    chk("lhu_reqc", reqc, 6);
    chk("lhu_busy", {31'b0, busy_bad}, 0);
    chk("lhu_lat", lat, 9);
    chk("lhu_data", load_data, 32'h0000_F00D);

    run_op(0, 3'b001, 32'h0000_0002, 0, 0, 1, 32'h8001_0000);
    chk("lh_data", load_data, 32'hFFFF_8001);
    run_op(0, 3'b100, 32'h0000_0001, 0, 1, 1, 32'h0000_9A00);
    chk("lbu_data", load_data, 32'h0000_009A);
    run_op(0, 3'b000, 32'h0000_0002, 0, 0, 1, 32'h0055_0000);
    chk("lb_pos", load_data, 32'h0000_0055);
    run_op(1, 3'b000, 32'h0000_0041, 32'h0000_00AB, 0, 1, 0);
    chk("sb_be", be_s, 4'b0010);
    chk("sb_wd", wd_s, 32'hABAB_ABAB);
    chk("sb_addr", ad_s, 32'h0000_0040);
    run_op(0, 3'b011, 32'h0000_0008, 0, 0, 1, 32'hCAFE_F00D);
    chk("lrsv_data", load_data, 32'hCAFE_F00D);
    run_op(1, 3'b100, 32'h0000_0004, 32'h1122_3344, 0, 1, 0);
    chk("srsv_be", be_s, 4'b1111);
    chk("srsv_wd", wd_s, 32'h1122_3344);

    // stale rvalid while idle is ignored
    @(negedge clk);
    rvalid = 1'b1; rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    rvalid = 1'b0;
    chk("stale_lv", {31'b0, load_valid}, 0);
    chk("stale_ld", load_data, 32'hCAFE_F00D);

    // reset during REQ drops dbus_req asynchronously
    @(negedge clk);
    op_valid = 1; op_is_store = 0; op_funct3 = 3'b010; op_addr = 32'h100;
    @(negedge clk);
    op_valid = 0;
    chk("rreq_req", {31'b0, dbus_req}, 1);
    rst = 1'b1;
    #1;
    chk("rreq_drop", {31'b0, dbus_req}, 0);
    @(negedge clk);
    rst = 1'b0;

    // reset during WAIT, then a stale rvalid
    run_op(0, 3'b010, 32'h200, 0, 0, 1, 32'h7777_7777);
    @(negedge clk);
    op_valid = 1; op_funct3 = 3'b010; op_addr = 32'h300;
    @(negedge clk);
    op_valid = 0; gnt = 1;
    @(negedge clk);
    gnt = 0;
    chk("rw_busy", {31'b0, lsu_busy}, 1);
    rst = 1'b1;
    #1;
    chk("rw_ld0", load_data, 0);
    chk("rw_busy0", {31'b0, lsu_busy}, 0);
    rvalid = 1'b1; rdata = 32'h1111_2222;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rvalid = 1'b0;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (load_valid || lsu_busy) n++;
      @(negedge clk);
    end
    chk("rw_noresp", n, 0);
    chk("rw_ld_keep", load_data, 0);

    // misaligned word load
    run_op(0, 3'b010, 32'h0000_3001, 0, 0, 1, 32'h5566_7788);
`ifdef MISALIGN_TRAP_EN
    chk("mis_noreq", reqc, 0);
    chk("mis_err", {30'b0, misaligned_err, load_valid}, 2'b11);
    chk("mis_ld", load_data, 0);
`else
    chk("mis_addr", ad_s, 32'h0000_3000);
    chk("mis_err", {30'b0, misaligned_err, load_valid}, 2'b01);
    chk("mis_ld", load_data, 32'h5566_7788);
`endif
    @(negedge clk);
    chk("mis_pulse1", {31'b0, misaligned_err}, 0);

    // timeout instance: prime load_data, then time out with no grant
    @(negedge clk); t_op_valid = 1;
    @(negedge clk); t_op_valid = 0; t_gnt = 1;
    @(negedge clk); t_gnt = 0; t_rvalid = 1; t_rdata = 32'hDEAD_BEEF;
    @(negedge clk); t_rvalid = 0;
    chk("to_prime", t_load_data, 32'hDEAD_BEEF);
    @(negedge clk); t_op_valid = 1;
    @(negedge clk); t_op_valid = 0;
    n = 0;
    while (t_dbus_req && n < 20) begin n++; @(negedge clk); end
    chk("to_reqc", n, 4);
    chk("to_err", {30'b0, t_bus_err, t_load_valid}, 2'b11);
    chk("to_ld", t_load_data, 0);
    @(negedge clk);
    chk("to_idle", {29'b0, t_bus_err, t_load_valid, t_lsu_busy}, 0);

    // response in the timeout cycle wins
    t_op_valid = 1;
    @(negedge clk); t_op_valid = 0; t_gnt = 1;
    @(negedge clk); t_gnt = 0;
    @(negedge clk);
    @(negedge clk); t_rvalid = 1; t_rdata = 32'h1357_2468;
    @(negedge clk); t_rvalid = 0;
    chk("tow_err", {30'b0, t_bus_err, t_load_valid}, 2'b01);
    chk("tow_ld", t_load_data, 32'h1357_2468);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
